wb_interconnect: RTL
====================

WB_INTERCONNECT -- requirements
Module: wb_interconnect

Interface
REQ-001 SHALL have parameter NSLAVES, default 4: number of Wishbone slave ports, range 1..16.
REQ-002 SHALL have parameter SLAVE_BASE, default all zeros, width NSLAVES*32: flat base addresses; slave k occupies bits [32k+31:32k].
REQ-003 SHALL have parameter SLAVE_SIZE, default all zeros, width NSLAVES*32: flat region sizes, each a power of two, with the base aligned to the size.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255: number of cycles to wait for a slave ack, range 1..65535.
REQ-005 wb_clk_i  in  1  clock; one clock, all logic on the rising edge.
REQ-006 wb_rst_i  in  1  reset; synchronous, active-high.
REQ-007 wbm_adr_i  in  32  master address.
REQ-008 wbm_dat_i  in  32  master write data.
REQ-009 wbm_we_i / wbm_sel_i / wbm_stb_i / wbm_cyc_i  in  1/4/1/1  master control.
REQ-010 wbm_dat_o  out  32  read data returned to the master.
REQ-011 wbm_ack_o / wbm_err_o  out  1/1  master termination signals.
REQ-012 wbs_adr_o / wbs_dat_o / wbs_we_o / wbs_sel_o  out  32/32/1/4  broadcast to all slaves.
REQ-013 wbs_cyc_o / wbs_stb_o  out  NSLAVES  one-hot per-slave strobes.
REQ-014 wbs_dat_i  in  NSLAVES*32  flat slave read data.
REQ-015 wbs_ack_i  in  NSLAVES  per-slave ack.
REQ-016 err_adr_o  out  32  address of the most recent errored access.
REQ-017 err_cause_o  out  2  cause of that error: 00 none, 01 unmapped, 10 timeout.

Function
REQ-018 Slave k SHALL match when (wbm_adr_i & ~(SIZE_k-1)) == BASE_k; on multiple matches the lowest index SHALL win.
REQ-019 FSM SHALL have states IDLE, DECODE, BUSY and ERR, all unlisted encodings recovering to IDLE.
REQ-020 In IDLE with wbm_cyc_i & wbm_stb_i, the FSM SHALL register the decoded index (sel_q) and hit flag, then enter DECODE.
REQ-021 DECODE SHALL last one cycle, then go to BUSY on a hit or to ERR on a miss.
REQ-022 In BUSY, wbs_cyc_o[sel_q] and wbs_stb_o[sel_q] SHALL equal wbm_cyc_i and wbm_stb_i; all other strobe bits SHALL be 0.
REQ-023 In BUSY, wbm_ack_o SHALL equal wbs_ack_i[sel_q] combinationally, and wbm_dat_o SHALL be slice sel_q of wbs_dat_i.
REQ-024 On an ack, the FSM SHALL return to IDLE next cycle.
REQ-025 Minimum access latency SHALL be 2 cycles from stb to ack when the slave acks combinationally.
REQ-026 ERR SHALL last exactly one cycle with wbm_err_o=1, wbm_ack_o=0 and wbm_dat_o=0.
REQ-027 On entry to ERR, the block SHALL capture err_adr_o and err_cause_o.
REQ-028 The FSM SHALL return to IDLE from ERR.
REQ-029 wbm_ack_o and wbm_err_o SHALL never be asserted together.
REQ-030 A wbm_cyc_i drop in DECODE, BUSY or ERR SHALL abort the access.
REQ-031 On abort, all slave strobes SHALL go to 0 the same cycle, the FSM SHALL go to IDLE next cycle, and no error SHALL be recorded.
REQ-032 While not in BUSY, all wbs_stb_o and wbs_cyc_o bits SHALL be 0, and wbm_dat_o SHALL be 0 outside BUSY.
REQ-033 wbs_adr_o, wbs_dat_o, wbs_we_o and wbs_sel_o SHALL pass the master inputs through unregistered.
REQ-034 A new access SHALL be accepted only from IDLE, so back-to-back accesses incur one IDLE cycle.

Reset
REQ-035 While wb_rst_i is high at a clock edge, the FSM SHALL go to IDLE, sel_q=0, the timeout counter=0, err_adr_o=0 and err_cause_o=00.
REQ-036 During reset, all strobes, wbm_ack_o and wbm_err_o SHALL be 0.
REQ-037 Reset asserted mid-access SHALL drop the slave strobe on the next edge without generating ack or err.

Configuration
REQ-038 Macro WB_INTERCONNECT_TIMEOUT_EN SHALL gate the timeout feature.
REQ-039 When WB_INTERCONNECT_TIMEOUT_EN is defined, a 16-bit counter SHALL clear on BUSY entry and increment each BUSY cycle without an ack.
REQ-040 With the timeout feature enabled, when the counter reaches TIMEOUT_CYCLES the strobe SHALL drop and the FSM SHALL enter ERR with cause 10.
REQ-041 When WB_INTERCONNECT_TIMEOUT_EN is undefined, no counter SHALL exist, BUSY SHALL wait indefinitely, and err_cause_o SHALL never equal 10.

Verification
REQ-042 Scenario: NSLAVES=4, read at BASE_2+0x8 with the slave returning 0xDEADBEEF -> wbs_stb_o=4'b0100, wbm_ack_o on cycle 2, wbm_dat_o=0xDEADBEEF.
REQ-043 Scenario: access to an unmapped 0x7000_0000 -> one-cycle wbm_err_o on cycle 2, no slave strobe, err_adr_o=0x7000_0000, err_cause_o=01.
REQ-044 Scenario: with TIMEOUT_EN and TIMEOUT_CYCLES=8, slave 1 never acks -> strobe high for 8 BUSY cycles, then wbm_err_o, err_cause_o=10.
REQ-045 Scenario: overlapping regions for slaves 0 and 3 -> only wbs_stb_o[0] asserts.
REQ-046 Scenario: wbm_cyc_i dropped in the second BUSY cycle -> strobes 0 the same cycle, FSM in IDLE next cycle, err_cause_o unchanged.
REQ-047 Scenario: wb_rst_i pulsed mid-BUSY -> no ack or err, all outputs at reset values, next access completes normally.

Source files
------------

// File: rtl/wb_interconnect.sv
// rtl/wb_interconnect.sv - single-master to NSLAVES-slave Wishbone address decoder and router
//
// Optional feature: define WB_INTERCONNECT_TIMEOUT_EN to enable the slave ack timeout.
//
// Ports:
//   wb_clk_i, wb_rst_i                    clock, synchronous active-high reset
//   wbm_adr_i/dat_i/we_i/sel_i/stb_i/cyc_i master request
//   wbm_dat_o/ack_o/err_o                 master response
//   wbs_adr_o/dat_o/we_o/sel_o            request broadcast to every slave
//   wbs_cyc_o/stb_o                       one-hot per-slave cycle and strobe
//   wbs_dat_i/ack_i                       flat per-slave read data and ack
//   err_adr_o/err_cause_o                 last errored address, cause (01 unmapped, 10 timeout)
module wb_interconnect #(
  parameter int                      NSLAVES        = 4,
  parameter logic [NSLAVES*32-1:0]   SLAVE_BASE     = '0,
  parameter logic [NSLAVES*32-1:0]   SLAVE_SIZE     = '0,
  parameter int                      TIMEOUT_CYCLES = 255
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic [31:0]           wbm_adr_i,
  input  logic [31:0]           wbm_dat_i,
  input  logic                  wbm_we_i,
  input  logic [3:0]            wbm_sel_i,
  input  logic                  wbm_stb_i,
  input  logic                  wbm_cyc_i,
  output logic [31:0]           wbm_dat_o,
  output logic                  wbm_ack_o,
  output logic                  wbm_err_o,
  output logic [31:0]           wbs_adr_o,
  output logic [31:0]           wbs_dat_o,
  output logic                  wbs_we_o,
  output logic [3:0]            wbs_sel_o,
  output logic [NSLAVES-1:0]    wbs_cyc_o,
  output logic [NSLAVES-1:0]    wbs_stb_o,
  input  logic [NSLAVES*32-1:0] wbs_dat_i,
  input  logic [NSLAVES-1:0]    wbs_ack_i,
  output logic [31:0]           err_adr_o,
  output logic [1:0]            err_cause_o
);

  localparam int IW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;

  if (NSLAVES < 1 || NSLAVES > 16 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("wb_interconnect: NSLAVES or TIMEOUT_CYCLES out of range");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    BUSY   = 2'd2,
    ERR    = 2'd3
  } state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   sel_q, dec_idx;
  logic            hit_q, dec_hit;
  logic [31:0]     adr_q;
  logic            ack_sel;
  logic            accept;
  logic            cap_err;
  logic [1:0]      cap_cause;
  logic [31:0]     slave_dat [NSLAVES];

`ifdef WB_INTERCONNECT_TIMEOUT_EN
  logic [15:0]     tmo_cnt;
`endif

  for (genvar g = 0; g < NSLAVES; g++) begin : g_dat
    assign slave_dat[g] = wbs_dat_i[32*g +: 32];
  end

  // Request fields go to every slave unregistered; only cyc/stb select the target.
  assign wbs_adr_o = wbm_adr_i;
  assign wbs_dat_o = wbm_dat_i;
  assign wbs_we_o  = wbm_we_i;
  assign wbs_sel_o = wbm_sel_i;

  assign ack_sel = wbs_ack_i[sel_q];
  assign accept  = (state == IDLE) && wbm_cyc_i && wbm_stb_i;

  // Scan from the highest index down so the lowest matching slave is the last write and wins.
  always_comb begin
    dec_idx = '0;
    dec_hit = 1'b0;
    for (int k = NSLAVES - 1; k >= 0; k--) begin
      if ((wbm_adr_i & ~(SLAVE_SIZE[32*k +: 32] - 32'd1)) == SLAVE_BASE[32*k +: 32]) begin
        dec_idx = IW'(k);
        dec_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    wbm_ack_o = 1'b0;
    wbm_err_o = 1'b0;
    wbm_dat_o = 32'd0;
    wbs_cyc_o = '0;
    wbs_stb_o = '0;
    cap_err   = 1'b0;
    cap_cause = 2'b00;
    case (state)
      IDLE: begin
        if (accept) state_nx = DECODE;
      end
      DECODE: begin
        if (!wbm_cyc_i) begin
          state_nx = IDLE;
        end else if (hit_q) begin
          state_nx = BUSY;
        end else begin
          state_nx  = ERR;
          cap_err   = 1'b1;
          cap_cause = 2'b01;
        end
      end
      BUSY: begin
        // Strobes are qualified by cyc so a dropped cycle releases the slave immediately.
        for (int k = 0; k < NSLAVES; k++) begin
          if (sel_q == IW'(k)) begin
            wbs_cyc_o[k] = wbm_cyc_i;
            wbs_stb_o[k] = wbm_cyc_i & wbm_stb_i;
          end
        end
        wbm_ack_o = ack_sel;
        wbm_dat_o = slave_dat[sel_q];
        if (!wbm_cyc_i || ack_sel) begin
          state_nx = IDLE;
`ifdef WB_INTERCONNECT_TIMEOUT_EN
        end else if (tmo_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
          // This is the last strobed cycle; the counter reaches the limit on the transition.
          state_nx  = ERR;
          cap_err   = 1'b1;
          cap_cause = 2'b10;
`endif
        end
      end
      ERR: begin
        wbm_err_o = wbm_cyc_i;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // State only updates at the edge, so hold every termination and strobe low while reset is high.
    if (wb_rst_i) begin
      wbm_ack_o = 1'b0;
      wbm_err_o = 1'b0;
      wbm_dat_o = 32'd0;
      wbs_cyc_o = '0;
      wbs_stb_o = '0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sel_q       <= '0;
      hit_q       <= 1'b0;
      adr_q       <= 32'd0;
      err_adr_o   <= 32'd0;
      err_cause_o <= 2'b00;
`ifdef WB_INTERCONNECT_TIMEOUT_EN
      tmo_cnt     <= 16'd0;
`endif
    end else begin
      if (accept) begin
        sel_q <= dec_idx;
        hit_q <= dec_hit;
        adr_q <= wbm_adr_i;
      end
      if (cap_err) begin
        err_adr_o   <= adr_q;
        err_cause_o <= cap_cause;
      end
`ifdef WB_INTERCONNECT_TIMEOUT_EN
      if (state == DECODE)
        tmo_cnt <= 16'd0;
      else if (state == BUSY && !ack_sel)
        tmo_cnt <= tmo_cnt + 16'd1;
`endif
    end
  end

endmodule
